// File: rtl/vga_line_fetch_sched.sv
// Framebuffer port scheduler: prefetches the next display line into a double-buffered
// line buffer while sharing the single memory port with a CPU requester.
module vga_line_fetch_sched #(
    parameter int HPIX   = 640,
    parameter int VPIX   = 480,
    parameter int VTOTAL = 525,
    parameter int HTOTAL = 1600,
    parameter int ADDR_W = 19,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    input  logic              mem_wait,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [23:0]       mem_wdata,
    input  logic [23:0]       mem_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [23:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [23:0]       cpu_rdata,
    output logic [23:0]       pixel_color,
    output logic              underrun
);

    localparam int COL_W = $clog2(HPIX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_issue_q, col_issue_d;
    logic [COL_W-1:0]    col_ret_q, col_ret_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                front_sel_q, front_sel_d;
    logic                underrun_q, underrun_d;
    logic                last_cpu_q, last_cpu_d;
    logic                run_q, run_d;
    logic [RD_LAT-1:0]   tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0]   tag_cpu_q, tag_cpu_d;
    logic [23:0]         pixel_q, pixel_d;
    logic [23:0]         cpu_rdata_q, cpu_rdata_d;

    logic [23:0]         lbuf0_q [0:HPIX-1];
    logic [23:0]         lbuf1_q [0:HPIX-1];

    logic [9:0]          nl_s;
    logic                fetch_start_s;
    logic                swap_s;
    logic                cpu_rd_busy_s;
    logic                disp_elig_s;
    logic                cpu_elig_s;
    logic                grant_cpu_s;
    logic                grant_disp_s;
    logic                cpu_rd_ret_s;
    logic                disp_ret_s;
    logic [9:0]          pix_col_s;

    // Line timing events derived from the raster counters
    always_comb begin
        nl_s          = (vcount == 10'(VTOTAL - 1)) ? 10'd0 : vcount + 10'd1;
        fetch_start_s = (hcount == 11'd0) && (nl_s < 10'(VPIX));
        swap_s        = (hcount == 11'(HTOTAL - 1));
        pix_col_s     = hcount[10:1];
    end

    // Eligibility and alternating-priority grant for the shared memory port
    always_comb begin
        cpu_rd_busy_s = |(tag_vld_q & tag_cpu_q);
        // no display issue on the swap cycle: that read would land in the new front buffer
        disp_elig_s   = run_q && (state_q == ST_FETCH) && (col_issue_q < COL_W'(HPIX)) && !swap_s;
        cpu_elig_s    = run_q && cpu_req && !cpu_rd_busy_s;
        grant_cpu_s   = 1'b0;
        grant_disp_s  = 1'b0;
        if (mem_wait) begin
            grant_cpu_s  = 1'b0;
            grant_disp_s = 1'b0;
        end else if (cpu_elig_s && disp_elig_s) begin
            grant_cpu_s  = ~last_cpu_q;
            grant_disp_s = last_cpu_q;
        end else begin
            grant_cpu_s  = cpu_elig_s;
            grant_disp_s = disp_elig_s;
        end
    end

    // Memory command, CPU response and return routing
    always_comb begin
        mem_rd       = grant_disp_s | (grant_cpu_s & ~cpu_we);
        mem_wr       = grant_cpu_s & cpu_we;
        mem_wdata    = (grant_cpu_s && cpu_we) ? cpu_wdata : 24'd0;
        if (grant_disp_s) begin
            mem_addr = base_q + ADDR_W'(col_issue_q);
        end else if (grant_cpu_s) begin
            mem_addr = cpu_addr;
        end else begin
            mem_addr = '0;
        end
        cpu_rd_ret_s = tag_vld_q[RD_LAT-1] & tag_cpu_q[RD_LAT-1];
        disp_ret_s   = tag_vld_q[RD_LAT-1] & ~tag_cpu_q[RD_LAT-1]
                       & (state_q == ST_FETCH) & (col_ret_q < COL_W'(HPIX));
        cpu_ack      = (grant_cpu_s & cpu_we) | cpu_rd_ret_s;
        cpu_rdata    = cpu_rd_ret_s ? mem_rdata : cpu_rdata_q;
        cpu_rdata_d  = cpu_rdata;
        last_cpu_d   = grant_cpu_s ? 1'b1 : (grant_disp_s ? 1'b0 : last_cpu_q);
        run_d        = 1'b1;
    end

    // Read tag pipe; a swap drops display reads still in flight
    always_comb begin
        tag_vld_d    = '0;
        tag_cpu_d    = '0;
        tag_vld_d[0] = mem_rd;
        tag_cpu_d[0] = grant_cpu_s & ~cpu_we;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_cpu_d[i] = tag_cpu_q[i-1];
        end
        for (int i = 0; i < RD_LAT; i++) begin
            tag_vld_d[i] = tag_vld_d[i] & (tag_cpu_d[i] | ~swap_s);
        end
    end

    // Fetch FSM, column counters, buffer swap and underrun flag
    always_comb begin
        state_d     = state_q;
        col_issue_d = col_issue_q;
        col_ret_d   = col_ret_q;
        base_d      = base_q;
        front_sel_d = front_sel_q;
        underrun_d  = underrun_q;
        case (state_q)
            ST_IDLE:  state_d = ST_IDLE;
            ST_FETCH: state_d = (col_ret_q == COL_W'(HPIX)) ? ST_DONE : ST_FETCH;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
        if (grant_disp_s) begin
            col_issue_d = col_issue_q + COL_W'(1);
        end else begin
            col_issue_d = col_issue_q;
        end
        if (disp_ret_s) begin
            col_ret_d = col_ret_q + COL_W'(1);
        end else begin
            col_ret_d = col_ret_q;
        end
        if (swap_s && (state_q == ST_FETCH || state_q == ST_DONE)) begin
            front_sel_d = ~front_sel_q;
            state_d     = ST_IDLE;
            if (state_q == ST_FETCH && col_ret_q != COL_W'(HPIX)) begin
                underrun_d = 1'b1;
            end else begin
                underrun_d = underrun_q;
            end
        end else if (fetch_start_s) begin
            state_d     = ST_FETCH;
            col_issue_d = '0;
            col_ret_d   = '0;
            base_d      = (ADDR_W'(nl_s) << 9) + (ADDR_W'(nl_s) << 7);
        end else begin
            front_sel_d = front_sel_q;
        end
    end

    // Pixel output from the front buffer, blanked outside the visible area
    always_comb begin
        if ((hcount < 11'(2 * HPIX)) && (vcount < 10'(VPIX))) begin
            pixel_d = front_sel_q ? lbuf1_q[pix_col_s] : lbuf0_q[pix_col_s];
        end else begin
            pixel_d = 24'd0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            col_issue_q <= '0;
            col_ret_q   <= '0;
            base_q      <= '0;
            front_sel_q <= 1'b0;
            underrun_q  <= 1'b0;
            last_cpu_q  <= 1'b0;
            run_q       <= 1'b0;
            tag_vld_q   <= '0;
            tag_cpu_q   <= '0;
            pixel_q     <= 24'd0;
            cpu_rdata_q <= 24'd0;
        end else begin
            state_q     <= state_d;
            col_issue_q <= col_issue_d;
            col_ret_q   <= col_ret_d;
            base_q      <= base_d;
            front_sel_q <= front_sel_d;
            underrun_q  <= underrun_d;
            last_cpu_q  <= last_cpu_d;
            run_q       <= run_d;
            tag_vld_q   <= tag_vld_d;
            tag_cpu_q   <= tag_cpu_d;
            pixel_q     <= pixel_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    // Line buffer storage: returns land in whichever buffer is not on display
    always_ff @(posedge clk) begin
        if (disp_ret_s) begin
            if (front_sel_q) begin
                lbuf0_q[col_ret_q] <= mem_rdata;
            end else begin
                lbuf1_q[col_ret_q] <= mem_rdata;
            end
        end
    end

    assign pixel_color = pixel_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_vga_line_fetch_sched.sv
// Directed bench for vga_line_fetch_sched: line prefetch, pixel output, CPU arbitration,
// wait-induced underrun and reset abandonment, against a 2-cycle-latency memory model.
module tb_vga_line_fetch_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        mem_wait;
    logic        mem_rd, mem_wr;
    logic [18:0] mem_addr;
    logic [23:0] mem_wdata, mem_rdata;
    logic        cpu_req, cpu_we;
    logic [18:0] cpu_addr;
    logic [23:0] cpu_wdata;
    logic        cpu_ack;
    logic [23:0] cpu_rdata, pixel_color;
    logic        underrun;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vga_line_fetch_sched dut (
        .clk(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
        .mem_wait(mem_wait), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .pixel_color(pixel_color), .underrun(underrun)
    );

    // Memory model: pattern data plus one write-back slot, RD_LAT = 2
    logic        ovr_vld = 1'b0;
    logic [18:0] ovr_addr = 19'd0;
    logic [23:0] ovr_data = 24'd0;
    logic [23:0] pipe0 = 24'd0;
    logic [23:0] pipe1 = 24'd0;

    function automatic logic [23:0] md(input logic [18:0] a);
        if (ovr_vld && a == ovr_addr) return ovr_data;
        return {5'b10101, a};
    endfunction

    always @(posedge clk) begin
        pipe0 <= mem_rd ? md(mem_addr) : 24'd0;
        pipe1 <= pipe0;
        if (mem_wr) begin
            ovr_vld  <= 1'b1;
            ovr_addr <= mem_addr;
            ovr_data <= mem_wdata;
        end
    end
    assign mem_rdata = pipe1;

    logic        req_n, wait_n;
    logic        track;
    logic [18:0] exp_base;
    int          rd_cnt, addr_bad, first_h, last_h, ack_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic start_track(input logic [18:0] b);
        track = 1'b1; exp_base = b; rd_cnt = 0; addr_bad = 0; first_h = -1; last_h = -1;
    endtask

    // One clock: apply raster position and pending inputs, then sample mid-cycle
    task automatic step(input int v, input int h);
        @(posedge clk);
        #1;
        vcount = 10'(v); hcount = 11'(h); cpu_req = req_n; mem_wait = wait_n;
        #1;
        if (track && mem_rd) begin
            if (first_h < 0) first_h = h;
            last_h = h;
            if (mem_addr != exp_base + 19'(rd_cnt)) addr_bad++;
            rd_cnt++;
        end
        if (cpu_ack) ack_cnt++;
    endtask

    typedef struct {
        int          v;
        int          h;
        logic [23:0] pix;
    } pix_vec_t;

    pix_vec_t vecs [10];
    int  alt_bad, rd_k, ack_k, blank_rd;
    logic [23:0] rdata_got;
    logic exp_w;

    initial begin
        vecs[0] = '{10, 10,   md(19'd6405)};
        vecs[1] = '{10, 11,   md(19'd6405)};
        vecs[2] = '{10, 2,    md(19'd6401)};
        vecs[3] = '{10, 1278, md(19'd7039)};
        vecs[4] = '{10, 1279, md(19'd7039)};
        vecs[5] = '{10, 1280, 24'd0};
        vecs[6] = '{10, 1598, 24'd0};
        vecs[7] = '{479, 10,  md(19'd6405)};
        vecs[8] = '{480, 10,  24'd0};
        vecs[9] = '{524, 10,  24'd0};

        reset_n = 1'b0; hcount = 11'd100; vcount = 10'd500; mem_wait = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 19'd0; cpu_wdata = 24'd0;
        req_n = 1'b0; wait_n = 1'b0; track = 1'b0; exp_base = 19'd0;
        rd_cnt = 0; addr_bad = 0; first_h = -1; last_h = -1; ack_cnt = 0;

        // Reset state and blanking
        step(500, 100); step(500, 100); step(500, 100);
        reset_n = 1'b1;
        step(500, 101); step(500, 102);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_pixel", 32'(pixel_color), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);

        // Line 9 prefetches line 10: 640 consecutive reads 6400..7039
        start_track(19'd6400);
        for (int h = 0; h < 1600; h++) step(9, h);
        chk("l9_rd_count", 32'(rd_cnt), 32'd640);
        chk("l9_addr_seq", 32'(addr_bad), 32'd0);
        chk("l9_first_h", 32'(first_h), 32'd1);
        chk("l9_last_h", 32'(last_h), 32'd640);
        step(10, 5);
        chk("l10_underrun", 32'(underrun), 32'd0);

        // Pixel vectors on the swapped-in front buffer
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].v, vecs[i].h);
            step(vecs[i].v, vecs[i].h);
            chk($sformatf("pix_v%0d_h%0d", vecs[i].v, vecs[i].h), 32'(pixel_color), 32'(vecs[i].pix));
        end

        // Lines 479..523 have no visible successor: no fetch at all
        track = 1'b0; blank_rd = 0;
        for (int v = 479; v < 524; v++) begin
            for (int h = 0; h < 4; h++) begin
                step(v, h);
                if (mem_rd) blank_rd++;
            end
        end
        chk("blank_no_rd", 32'(blank_rd), 32'd0);

        // Last line wraps: fetch of line 0 starts at address 0
        start_track(19'd0);
        for (int h = 0; h <= 700; h++) step(524, h);
        chk("l524_rd_count", 32'(rd_cnt), 32'd640);
        chk("l524_addr_seq", 32'(addr_bad), 32'd0);
        chk("l524_first_h", 32'(first_h), 32'd1);
        step(524, 1599);

        // CPU writes during a fetch alternate with display reads
        start_track(19'd13440);
        for (int h = 0; h < 10; h++) step(20, h);
        cpu_we = 1'b1; cpu_addr = 19'h00100; cpu_wdata = 24'hABCDEF;
        req_n = 1'b1; alt_bad = 0; ack_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step(20, 10 + k);
            exp_w = ((k % 2) == 0);
            if (mem_wr !== exp_w || mem_rd !== !exp_w || cpu_ack !== exp_w) alt_bad++;
            if (exp_w && (mem_addr !== 19'h00100 || mem_wdata !== 24'hABCDEF)) alt_bad++;
            if (ack_cnt >= 4) req_n = 1'b0;
        end
        chk("wr_alternate", 32'(alt_bad), 32'd0);
        chk("wr_ack_count", 32'(ack_cnt), 32'd4);
        for (int h = 18; h < 1600; h++) step(20, h);
        chk("wr_fetch_count", 32'(rd_cnt), 32'd640);
        chk("wr_fetch_addr", 32'(addr_bad), 32'd0);
        step(21, 5);
        chk("wr_underrun", 32'(underrun), 32'd0);
        step(21, 2); step(21, 3);
        chk("l21_pixel1", 32'(pixel_color), 32'(md(19'd13441)));

        // CPU read of the written word: ack two cycles after its mem_rd
        track = 1'b0; cpu_we = 1'b0; req_n = 1'b1; rd_k = -1; ack_k = -1;
        rdata_got = 24'd0; ack_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step(21, 10 + k);
            if (mem_rd && mem_addr == 19'h00100 && rd_k < 0) rd_k = k;
            if (cpu_ack && ack_k < 0) begin
                ack_k = k; rdata_got = cpu_rdata; req_n = 1'b0;
            end
        end
        chk("rd_issue_cycle", 32'(rd_k), 32'd0);
        chk("rd_ack_cycle", 32'(ack_k), 32'd2);
        chk("rd_data", 32'(rdata_got), 32'hABCDEF);
        chk("rd_ack_count", 32'(ack_cnt), 32'd1);

        // mem_wait held for 1000 cycles: fetch cannot finish, underrun sets
        start_track(19'd19840);
        step(30, 0);
        wait_n = 1'b1;
        for (int h = 1; h <= 1000; h++) step(30, h);
        chk("wait_no_rd", 32'(rd_cnt), 32'd0);
        wait_n = 1'b0;
        for (int h = 1001; h < 1600; h++) step(30, h);
        chk("wait_partial_rd", 32'(rd_cnt), 32'd598);
        start_track(19'd20480);
        step(31, 0);
        chk("wait_underrun", 32'(underrun), 32'd1);
        for (int h = 1; h < 1600; h++) step(31, h);
        chk("post_ur_rd_count", 32'(rd_cnt), 32'd640);
        chk("post_ur_addr_seq", 32'(addr_bad), 32'd0);
        chk("post_ur_first_h", 32'(first_h), 32'd1);
        step(32, 5);
        chk("underrun_sticky", 32'(underrun), 32'd1);
        step(32, 6); step(32, 7);
        chk("l32_pixel3", 32'(pixel_color), 32'(md(19'd20483)));

        // Reset mid-fetch with a CPU read in flight
        track = 1'b0;
        for (int h = 0; h < 10; h++) step(40, h);
        cpu_we = 1'b0; cpu_addr = 19'h00100; req_n = 1'b1;
        step(40, 10);
        chk("mid_cpu_rd_issued", 32'({mem_rd, mem_addr}), 32'({1'b1, 19'h00100}));
        @(posedge clk);
        #1;
        reset_n = 1'b0; req_n = 1'b0; cpu_req = 1'b0; hcount = 11'd11;
        #1;
        chk("mid_rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_pixel", 32'(pixel_color), 32'd0);
        chk("mid_rst_underrun", 32'(underrun), 32'd0);
        ack_cnt = 0;
        step(40, 12); step(40, 13);
        reset_n = 1'b1;
        for (int h = 14; h <= 30; h++) step(40, h);
        chk("no_stale_ack", 32'(ack_cnt), 32'd0);
        start_track(19'd26240);
        for (int h = 0; h <= 700; h++) step(40, h);
        chk("clean_rd_count", 32'(rd_cnt), 32'd640);
        chk("clean_addr_seq", 32'(addr_bad), 32'd0);
        chk("clean_first_h", 32'(first_h), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
